mem_port_arbiter: RTL

Two-requester arbiter sharing the single-port combined instruction/data memory between the CPU fetch stage and the load/store stage. It grants at most one access per cycle, drives the memory address, write-enable and write-data lines, and returns registered read data with a one-cycle response pulse. A starvation counter guarantees fetch progress under continuous data traffic. Misaligned and out-of-range accesses are flagged as errors.

---
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Summary  : Fetch / load-store arbiter for a shared single-port memory with
//            starvation guard, address error flagging and registered responses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int WORD_SIZE = 32,
  parameter int RAM_SIZE  = 1024,
  parameter int MAX_WAIT  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [WORD_SIZE-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_err,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int            c_aw        = $clog2(RAM_SIZE);
  localparam int            c_cw        = $clog2(MAX_WAIT + 1);
  localparam logic [c_aw-1:0] c_last_word = c_aw'(RAM_SIZE - 4);
  localparam logic [c_cw-1:0] c_max_wait  = c_cw'(MAX_WAIT);

  logic [c_cw-1:0]      r_wait_cnt;
  logic                 r_if_rvalid;
  logic                 r_if_err;
  logic [WORD_SIZE-1:0] r_if_rdata;
  logic                 r_d_rvalid;
  logic                 r_d_err;
  logic [WORD_SIZE-1:0] r_d_rdata;
  logic                 w_fetch_forced;
  logic                 w_if_err;
  logic                 w_d_err;

  // Misaligned, above the memory, or a word that would run past the last byte.
  function automatic logic addr_err(input logic [WORD_SIZE-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> c_aw) != '0) || (a[c_aw-1:0] > c_last_word);
  endfunction

  assign w_if_err       = addr_err(if_addr);
  assign w_d_err        = addr_err(d_addr);
  assign w_fetch_forced = (r_wait_cnt == c_max_wait);

  assign if_gnt = rst_n & if_req & (~d_req | w_fetch_forced);
  assign d_gnt  = rst_n & d_req & ~(if_req & w_fetch_forced);

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_we    = d_we & ~w_d_err;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  // Counts consecutive cycles in which a pending fetch lost to the data port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      r_wait_cnt <= '0;
    end else if (d_gnt && (r_wait_cnt != c_max_wait)) begin
      r_wait_cnt <= r_wait_cnt + c_cw'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rvalid <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_if_rvalid <= if_gnt;
      r_d_rvalid  <= d_gnt;
      if (if_gnt) begin
        r_if_err   <= w_if_err;
        r_if_rdata <= w_if_err ? '0 : mem_rdata;
      end
      if (d_gnt) begin
        r_d_err   <= w_d_err;
        r_d_rdata <= (w_d_err | d_we) ? '0 : mem_rdata;
      end
    end
  end

  assign if_rvalid = r_if_rvalid;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire
